// File: rtl/wf68k30l_pkg.sv
// Shared WF68K30L bus definitions: function codes, SIZ encodings and the
// bus responder state type.
package wf68k30l_pkg;

  localparam logic [2:0] FC_USER_DATA  = 3'd1;
  localparam logic [2:0] FC_USER_PROG  = 3'd2;
  localparam logic [2:0] FC_SUPER_DATA = 3'd5;
  localparam logic [2:0] FC_SUPER_PROG = 3'd6;
  localparam logic [2:0] FC_CPU_SPACE  = 3'd7;

  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT,
    ACCESS,
    ACK
  } bus_resp_state_t;

endpackage

// File: rtl/wf68k30l_bus_lane_decode.sv
// Byte-lane enables for a 32-bit port from SIZ1:0 and A1:0; lanes past D7:0
// are left for the core to rerun under dynamic bus sizing.
module wf68k30l_bus_lane_decode
  import wf68k30l_pkg::*;
(
  input  logic [1:0] size_in,
  input  logic [1:0] a_lo,
  output logic [3:0] be
);

  logic [2:0] n_bytes;
  logic [2:0] lane_end;

  always_comb begin
    n_bytes = 3'd4;
    case (size_in)
      SIZ_LONG:  n_bytes = 3'd4;
      SIZ_BYTE:  n_bytes = 3'd1;
      SIZ_WORD:  n_bytes = 3'd2;
      SIZ_3BYTE: n_bytes = 3'd3;
    endcase
    // One past the last lane; may exceed 4 when the operand is misaligned.
    lane_end = {1'b0, a_lo} + n_bytes;
    be = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) >= {1'b0, a_lo}) && (3'(i) < lane_end)) begin
        be[3-i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wf68k30l_bus_responder.sv
// Responder end of the WF68K30L asynchronous bus: one on-chip RAM window as a
// 32-bit port, plus interrupt-acknowledge cycles answered by vector or autovector.
module wf68k30l_bus_responder
  import wf68k30l_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          ADR_BITS    = 16,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] PROT_BYTES  = 16'h0400
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         ADR_IN,
  input  logic [2:0]          FC_IN,
  input  logic [1:0]          SIZE_IN,
  input  logic                RWn,
  input  logic                ASn,
  input  logic                DSn,
  input  logic [31:0]         DATA_IN,
  output logic [31:0]         DATA_OUT,
  output logic                DATA_EN,
  output logic [1:0]          DSACKn,
  output logic                BERRn,
  output logic                AVECn,
  input  logic [7:0]          IRQ_VEC,
  input  logic                IRQ_AUTO,
  output logic [ADR_BITS-3:0] MEM_ADR,
  output logic                MEM_WE,
  output logic [3:0]          MEM_BE,
  output logic [31:0]         MEM_WDATA,
  input  logic [31:0]         MEM_RDATA
);

  localparam logic [32:0] WIN_SIZE = 33'd1 << ADR_BITS;
  localparam logic [3:0]  WS_M1    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  bus_resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_out_q, data_out_d;
  logic        data_en_q, data_en_d;
  logic [1:0]  dsack_q, dsack_d;
  logic        berr_q, berr_d;
  logic        avec_q, avec_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;

  logic [31:0] offset;
  logic        in_win, is_iack, is_ram, fc_mem, prot_hit;
  logic [3:0]  lane_be;

  wf68k30l_bus_lane_decode u_lane (
    .size_in (SIZE_IN),
    .a_lo    (ADR_IN[1:0]),
    .be      (lane_be)
  );

  // RAM address follows the bus directly so read data is ready by ACCESS.
  assign MEM_ADR   = ADR_IN[ADR_BITS-1:2];
  assign MEM_WDATA = DATA_IN;

  assign offset   = ADR_IN - BASE_ADR;
  assign in_win   = (ADR_IN >= BASE_ADR) && ({1'b0, offset} < WIN_SIZE);
  assign fc_mem   = (FC_IN == FC_USER_DATA) || (FC_IN == FC_USER_PROG) ||
                    (FC_IN == FC_SUPER_DATA) || (FC_IN == FC_SUPER_PROG);
  assign prot_hit = !FC_IN[2] && (offset < {16'd0, PROT_BYTES});
  assign is_iack  = (FC_IN == FC_CPU_SPACE) && (ADR_IN[19:16] == 4'hF);
  assign is_ram   = in_win && fc_mem && !prot_hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    data_en_d  = data_en_q;
    dsack_d    = dsack_q;
    berr_d     = berr_q;
    avec_d     = avec_q;
    we_d       = we_q;
    be_d       = be_q;
    case (state_q)
      IDLE: begin
        if (!ASn && (RWn || !DSn)) state_d = DECODE;
      end
      DECODE: begin
        if (is_iack) begin
          state_d = ACK;
          if (IRQ_AUTO) begin
            avec_d = 1'b0;
          end else begin
            dsack_d    = 2'b00;
            data_en_d  = 1'b1;
            data_out_d = {IRQ_VEC, 16'h0000, IRQ_VEC};
          end
        end else if (is_ram) begin
          be_d = RWn ? 4'b1111 : lane_be;
          if (WAIT_STATES == 0) begin
            state_d = ACCESS;
            we_d    = !RWn;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_M1;
          end
        end else begin
          state_d = ACK;
          berr_d  = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
          we_d    = !RWn;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        we_d    = 1'b0;
        state_d = ACK;
        dsack_d = 2'b00;
        if (RWn) begin
          data_out_d = MEM_RDATA;
          data_en_d  = 1'b1;
        end
      end
      ACK: ;
      default: state_d = IDLE;
    endcase
    // Strobe negation ends the cycle from any active state, aborting if early.
    if (ASn && (state_q != IDLE)) begin
      state_d    = IDLE;
      cnt_d      = 4'd0;
      data_out_d = 32'd0;
      data_en_d  = 1'b0;
      dsack_d    = 2'b11;
      berr_d     = 1'b1;
      avec_d     = 1'b1;
      we_d       = 1'b0;
      be_d       = 4'b0000;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      data_out_q <= 32'd0;
      data_en_q  <= 1'b0;
      dsack_q    <= 2'b11;
      berr_q     <= 1'b1;
      avec_q     <= 1'b1;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      data_en_q  <= data_en_d;
      dsack_q    <= dsack_d;
      berr_q     <= berr_d;
      avec_q     <= avec_d;
      we_q       <= we_d;
      be_q       <= be_d;
    end
  end

  assign DATA_OUT = data_out_q;
  assign DATA_EN  = data_en_q;
  assign DSACKn   = dsack_q;
  assign BERRn    = berr_q;
  assign AVECn    = avec_q;
  assign MEM_WE   = we_q;
  assign MEM_BE   = be_q;

endmodule

// File: tb/tb_wf68k30l_bus_responder.sv
// Directed bench for wf68k30l_bus_responder with default parameters
// (window at 0, 64 KiB, one wait state, first 1 KiB supervisor-only).
module tb_wf68k30l_bus_responder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ADR_IN;
  logic [2:0]  FC_IN;
  logic [1:0]  SIZE_IN;
  logic        RWn;
  logic        ASn;
  logic        DSn;
  logic [31:0] DATA_IN;
  logic [31:0] DATA_OUT;
  logic        DATA_EN;
  logic [1:0]  DSACKn;
  logic        BERRn;
  logic        AVECn;
  logic [7:0]  IRQ_VEC;
  logic        IRQ_AUTO;
  logic [13:0] MEM_ADR;
  logic        MEM_WE;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  logic [3:0] we_be = 4'h0;
  int lat;
  int we0;

  wf68k30l_bus_responder dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ADR_IN    (ADR_IN),
    .FC_IN     (FC_IN),
    .SIZE_IN   (SIZE_IN),
    .RWn       (RWn),
    .ASn       (ASn),
    .DSn       (DSn),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .DATA_EN   (DATA_EN),
    .DSACKn    (DSACKn),
    .BERRn     (BERRn),
    .AVECn     (AVECn),
    .IRQ_VEC   (IRQ_VEC),
    .IRQ_AUTO  (IRQ_AUTO),
    .MEM_ADR   (MEM_ADR),
    .MEM_WE    (MEM_WE),
    .MEM_BE    (MEM_BE),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  // Write strobes as the RAM would see them, away from the active edge.
  always @(negedge CLK) begin
    if (MEM_WE === 1'b1) begin
      we_cnt <= we_cnt + 1;
      we_be  <= MEM_BE;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [2:0] fc, input logic [1:0] sz,
                       input logic rw, input logic [31:0] d);
    ADR_IN  = a;
    FC_IN   = fc;
    SIZE_IN = sz;
    RWn     = rw;
    DATA_IN = d;
    ASn     = 1'b0;
    DSn     = 1'b0;
  endtask

  task automatic wait_term(output int clks);
    clks = 99;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (DSACKn != 2'b11 || BERRn == 1'b0 || AVECn == 1'b0) begin
        clks = i + 1;
        break;
      end
    end
  endtask

  task automatic end_cycle(input string tag);
    ASn = 1'b1;
    DSn = 1'b1;
    tick();
    chk({tag, "_idle_dsack"}, 32'(DSACKn), 32'h3);
    chk({tag, "_idle_berr"}, 32'(BERRn), 32'h1);
    chk({tag, "_idle_avec"}, 32'(AVECn), 32'h1);
    chk({tag, "_idle_den"}, 32'(DATA_EN), 32'h0);
    chk({tag, "_idle_be"}, 32'(MEM_BE), 32'h0);
  endtask

  initial begin
    RESET = 1'b1;
    ADR_IN = 32'd0; FC_IN = 3'd0; SIZE_IN = 2'b00; RWn = 1'b1;
    ASn = 1'b1; DSn = 1'b1; DATA_IN = 32'd0;
    IRQ_VEC = 8'h00; IRQ_AUTO = 1'b0; MEM_RDATA = 32'd0;
    tick(); tick();
    chk("rst_dsack", 32'(DSACKn), 32'h3);
    chk("rst_berr", 32'(BERRn), 32'h1);
    chk("rst_avec", 32'(AVECn), 32'h1);
    chk("rst_den", 32'(DATA_EN), 32'h0);
    chk("rst_dout", DATA_OUT, 32'h0);
    chk("rst_we", 32'(MEM_WE), 32'h0);
    chk("rst_be", 32'(MEM_BE), 32'h0);
    RESET = 1'b0;
    tick();

    // Supervisor long read at 0x400: 3 + 1 wait state clocks.
    MEM_RDATA = 32'hDEADBEEF;
    we0 = we_cnt;
    start(32'h0000_0400, 3'b101, 2'b00, 1'b1, 32'h0);
    wait_term(lat);
    chk("rd_lat", 32'(lat), 32'd4);
    chk("rd_dsack", 32'(DSACKn), 32'h0);
    chk("rd_data", DATA_OUT, 32'hDEADBEEF);
    chk("rd_den", 32'(DATA_EN), 32'h1);
    chk("rd_be", 32'(MEM_BE), 32'hF);
    chk("rd_madr", 32'(MEM_ADR), 32'h100);
    end_cycle("rd");
    chk("rd_no_we", 32'(we_cnt), 32'(we0));

    // User byte write at offset 0x402 lands in D15:8.
    we0 = we_cnt;
    start(32'h0000_0402, 3'b001, 2'b01, 1'b0, 32'h0000_A500);
    wait_term(lat);
    chk("bw_lat", 32'(lat), 32'd4);
    chk("bw_dsack", 32'(DSACKn), 32'h0);
    chk("bw_wdata", MEM_WDATA, 32'h0000_A500);
    chk("bw_madr", 32'(MEM_ADR), 32'h100);
    end_cycle("bw");
    chk("bw_we_cnt", 32'(we_cnt - we0), 32'd1);
    chk("bw_we_be", 32'(we_be), 32'h2);

    // Word write at A1:0=11 only reaches the last lane.
    we0 = we_cnt;
    start(32'h0000_0803, 3'b101, 2'b10, 1'b0, 32'h1234_5678);
    wait_term(lat);
    chk("ww_dsack", 32'(DSACKn), 32'h0);
    end_cycle("ww");
    chk("ww_we_cnt", 32'(we_cnt - we0), 32'd1);
    chk("ww_we_be", 32'(we_be), 32'h1);

    // Misaligned long write at A1:0=01 takes three lanes.
    we0 = we_cnt;
    start(32'h0000_0805, 3'b101, 2'b00, 1'b0, 32'h1122_3344);
    wait_term(lat);
    chk("lw_dsack", 32'(DSACKn), 32'h0);
    end_cycle("lw");
    chk("lw_we_cnt", 32'(we_cnt - we0), 32'd1);
    chk("lw_we_be", 32'(we_be), 32'h7);

    // User access inside the protected region is a bus error.
    we0 = we_cnt;
    start(32'h0000_0010, 3'b001, 2'b00, 1'b1, 32'h0);
    wait_term(lat);
    chk("prot_lat", 32'(lat), 32'd2);
    chk("prot_berr", 32'(BERRn), 32'h0);
    chk("prot_dsack", 32'(DSACKn), 32'h3);
    chk("prot_den", 32'(DATA_EN), 32'h0);
    end_cycle("prot");
    chk("prot_no_we", 32'(we_cnt), 32'(we0));

    // Supervisor at the same address is served.
    MEM_RDATA = 32'hCAFE_F00D;
    start(32'h0000_0010, 3'b101, 2'b00, 1'b1, 32'h0);
    wait_term(lat);
    chk("sup_lat", 32'(lat), 32'd4);
    chk("sup_dsack", 32'(DSACKn), 32'h0);
    chk("sup_berr", 32'(BERRn), 32'h1);
    chk("sup_data", DATA_OUT, 32'hCAFE_F00D);
    end_cycle("sup");

    // Last longword of the window, then the first address past it.
    start(32'h0000_FFFC, 3'b110, 2'b00, 1'b1, 32'h0);
    wait_term(lat);
    chk("top_dsack", 32'(DSACKn), 32'h0);
    end_cycle("top");
    start(32'h0001_0000, 3'b101, 2'b00, 1'b1, 32'h0);
    wait_term(lat);
    chk("oow_lat", 32'(lat), 32'd2);
    chk("oow_berr", 32'(BERRn), 32'h0);
    chk("oow_dsack", 32'(DSACKn), 32'h3);
    end_cycle("oow");

    // Interrupt acknowledge with a supplied vector.
    IRQ_VEC = 8'h40;
    IRQ_AUTO = 1'b0;
    start(32'h000F_0008, 3'b111, 2'b01, 1'b1, 32'h0);
    wait_term(lat);
    chk("iack_lat", 32'(lat), 32'd2);
    chk("iack_dsack", 32'(DSACKn), 32'h0);
    chk("iack_vec_lo", 32'(DATA_OUT[7:0]), 32'h40);
    chk("iack_vec_hi", 32'(DATA_OUT[31:24]), 32'h40);
    chk("iack_den", 32'(DATA_EN), 32'h1);
    chk("iack_avec", 32'(AVECn), 32'h1);
    end_cycle("iack");

    // Interrupt acknowledge answered by autovector.
    IRQ_AUTO = 1'b1;
    start(32'h000F_0008, 3'b111, 2'b01, 1'b1, 32'h0);
    wait_term(lat);
    chk("avec_lat", 32'(lat), 32'd2);
    chk("avec_avec", 32'(AVECn), 32'h0);
    chk("avec_dsack", 32'(DSACKn), 32'h3);
    chk("avec_berr", 32'(BERRn), 32'h1);
    end_cycle("avec");
    IRQ_AUTO = 1'b0;

    // Other CPU-space cycles are bus errors.
    start(32'h0002_0000, 3'b111, 2'b00, 1'b1, 32'h0);
    wait_term(lat);
    chk("cpu_berr", 32'(BERRn), 32'h0);
    chk("cpu_dsack", 32'(DSACKn), 32'h3);
    end_cycle("cpu");

    // Strobe negated during WAIT: cycle abandoned, nothing written.
    we0 = we_cnt;
    start(32'h0000_0500, 3'b101, 2'b00, 1'b0, 32'hAAAA_5555);
    tick();
    tick();
    chk("abt_wait_be", 32'(MEM_BE), 32'hF);
    chk("abt_wait_dsack", 32'(DSACKn), 32'h3);
    ASn = 1'b1;
    DSn = 1'b1;
    tick();
    chk("abt_be", 32'(MEM_BE), 32'h0);
    chk("abt_dsack", 32'(DSACKn), 32'h3);
    tick();
    tick();
    chk("abt_no_we", 32'(we_cnt), 32'(we0));

    // Reset while in ACCESS: outputs drop at once, the write never reaches RAM.
    we0 = we_cnt;
    start(32'h0000_0600, 3'b101, 2'b00, 1'b0, 32'h0BAD_F00D);
    tick();
    tick();
    tick();
    chk("rst_acc_be", 32'(MEM_BE), 32'hF);
    RESET = 1'b1;
    ASn = 1'b1;
    DSn = 1'b1;
    #1;
    chk("rst_acc_we", 32'(MEM_WE), 32'h0);
    chk("rst_acc_be0", 32'(MEM_BE), 32'h0);
    chk("rst_acc_dsack", 32'(DSACKn), 32'h3);
    tick();
    RESET = 1'b0;
    tick();
    tick();
    chk("rst_acc_no_we", 32'(we_cnt), 32'(we0));
    chk("rst_acc_idle", 32'(DSACKn), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
